// File: rtl/pipe_latch.sv
// Generic pipeline stage latch: WIDTH-bit payload under valid/ready with flush
// and a saturating backpressure counter. Define PIPE_LATCH_SKID_EN for the two-entry skid build.
module pipe_latch #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

`ifdef PIPE_LATCH_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1
    } state_t;
`endif

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   main_r;
    logic [WIDTH-1:0]   main_s;
    logic               load_main_s;
    logic               in_xfer_s;
    logic               out_xfer_s;
    logic [CNT_W-1:0]   stall_cnt_r;

    assign out_valid  = (state_r != ST_EMPTY);
    assign out_data   = main_r;
    assign stall_cnt  = stall_cnt_r;
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready;

`ifdef PIPE_LATCH_SKID_EN
    logic [WIDTH-1:0]   skid_r;
    logic               load_skid_s;
    logic               main_from_skid_s;

    // Ready depends on the state register alone, so no combinational path from out_ready.
    assign in_ready = (state_r != ST_SKID);
    assign main_s   = main_from_skid_s ? skid_r : in_data;

    // Next-state and payload load decode for the skid build
    always_comb begin
        state_s          = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_s     = ST_FULL;
                        load_main_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s && out_xfer_s) begin
                        load_main_s = 1'b1;
                    end else if (in_xfer_s) begin
                        state_s     = ST_SKID;
                        load_skid_s = 1'b1;
                    end else if (out_xfer_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_xfer_s) begin
                        state_s          = ST_FULL;
                        load_main_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_s = ST_SKID;
                    end
                end
                default: state_s = ST_EMPTY;
            endcase
        end
    end

    // Skid register captures the entry accepted while the head is stalled
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skid_r <= {WIDTH{1'b0}};
        end else if (load_skid_s) begin
            skid_r <= in_data;
        end else begin
            skid_r <= skid_r;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign main_s   = in_data;

    // Next-state and head load decode for the single-register build
    always_comb begin
        state_s     = state_r;
        load_main_s = 1'b0;
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_s     = ST_FULL;
                        load_main_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s) begin
                        load_main_s = 1'b1;
                    end else if (out_xfer_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: state_s = ST_EMPTY;
            endcase
        end
    end
`endif

    // State register; flush is folded into state_s, payloads keep stale data
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_EMPTY;
            main_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            main_r  <= load_main_s ? main_s : main_r;
        end
    end

    // Saturating count of cycles the head waits on downstream; flush does not clear it
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule
